// File: rtl/arc4_pkg.sv
// Shared types and constants for the arc4 brute-force key search controller.
package arc4_pkg;

  localparam int KEY_W = 24;

  localparam logic [7:0] PRINT_LO_DEFAULT = 8'h20;
  localparam logic [7:0] PRINT_HI_DEFAULT = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    CORE_RST,
    WAIT_RDY,
    RUN,
    NEXT,
    FOUND,
    EXHAUSTED
  } search_state_t;

endpackage

// File: rtl/arc4_key_search_pt_snoop.sv
// Printable-byte checker on the core's plaintext write port; the length byte at
// address 0 is exempt. bad_now is combinational so the caller can abort at once.
module pt_snoop
  import arc4_pkg::*;
#(
  parameter logic [7:0] PRINT_LO = PRINT_LO_DEFAULT,
  parameter logic [7:0] PRINT_HI = PRINT_HI_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       check_en,
  input  logic       pt_wren,
  input  logic [7:0] pt_addr,
  input  logic [7:0] pt_wrdata,
  output logic       bad_now,
  output logic       bad_seen
);

  assign bad_now = check_en && pt_wren && (pt_addr != 8'd0) &&
                   ((pt_wrdata < PRINT_LO) || (pt_wrdata > PRINT_HI));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      bad_seen <= 1'b0;
    end else if (bad_now) begin
      bad_seen <= 1'b1;
    end
  end

endmodule

// File: rtl/arc4_key_search.sv
// Sequences one arc4 core through candidate keys, rejecting any key whose
// plaintext contains a non-printable byte and accepting the first clean finish.
module arc4_key_search
  import arc4_pkg::*;
#(
  parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
  parameter logic [KEY_W-1:0] KEY_STEP  = 24'h000001,
  parameter logic [KEY_W-1:0] KEY_LAST  = 24'hFFFFFF,
  parameter logic [7:0]       PRINT_LO  = PRINT_LO_DEFAULT,
  parameter logic [7:0]       PRINT_HI  = PRINT_HI_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic [KEY_W-1:0] attempts,
  output logic             arc4_rst_n,
  output logic             arc4_en,
  input  logic             arc4_rdy,
  output logic [KEY_W-1:0] arc4_key,
  input  logic             pt_wren,
  input  logic [7:0]       pt_addr,
  input  logic [7:0]       pt_wrdata
);

  search_state_t    state;
  logic [KEY_W-1:0] cand;
  logic             started;
  logic             busy_seen;
  logic             bad_now;
  logic             bad_seen;
  logic [KEY_W:0]   next_sum;

  pt_snoop #(
    .PRINT_LO (PRINT_LO),
    .PRINT_HI (PRINT_HI)
  ) u_snoop (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == CORE_RST),
    .check_en  (state == RUN),
    .pt_wren   (pt_wren),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .bad_now   (bad_now),
    .bad_seen  (bad_seen)
  );

  // One extra bit so stepping past 24'hFFFFFF cannot wrap back into range.
  assign next_sum = {1'b0, cand} + {1'b0, KEY_STEP};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdy        <= 1'b1;
      key_valid  <= 1'b0;
      key        <= '0;
      attempts   <= '0;
      arc4_rst_n <= 1'b0;
      arc4_en    <= 1'b0;
      arc4_key   <= KEY_START;
      cand       <= KEY_START;
      started    <= 1'b0;
      busy_seen  <= 1'b0;
    end else begin
      arc4_en <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            rdy        <= 1'b0;
            key_valid  <= 1'b0;
            attempts   <= '0;
            cand       <= KEY_START;
            arc4_rst_n <= 1'b0;
            state      <= CORE_RST;
          end
        end
        CORE_RST: begin
          arc4_rst_n <= 1'b1;
          arc4_key   <= cand;
          attempts   <= attempts + 24'd1;
          started    <= 1'b0;
          busy_seen  <= 1'b0;
          state      <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (arc4_rdy) begin
            arc4_en <= 1'b1;
            started <= 1'b1;
            state   <= RUN;
          end
        end
        // A stale rdy right after the en pulse must not count as completion.
        RUN: begin
          if (bad_now || bad_seen) begin
            state <= NEXT;
          end else if (arc4_rdy && busy_seen && started) begin
            state <= FOUND;
          end else if (!arc4_rdy) begin
            busy_seen <= 1'b1;
          end
        end
        NEXT: begin
          if (next_sum > {1'b0, KEY_LAST}) begin
            state <= EXHAUSTED;
          end else begin
            cand       <= next_sum[KEY_W-1:0];
            arc4_rst_n <= 1'b0;
            state      <= CORE_RST;
          end
        end
        FOUND: begin
          key       <= cand;
          key_valid <= 1'b1;
          rdy       <= 1'b1;
          state     <= IDLE;
        end
        EXHAUSTED: begin
          key_valid <= 1'b0;
          rdy       <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
